// File: rtl/cvmcu_intr_pkg.sv
// rtl/cvmcu_intr_pkg.sv - shared sizes and types for the CV-MCU interrupt controller
package cvmcu_intr_pkg;

  localparam int CVMCU_INTR_NUM_IRQ = 32;
  localparam int CVMCU_INTR_ID_W    = 5;

  typedef logic [CVMCU_INTR_NUM_IRQ-1:0] cvmcu_intr_vec_t;
  typedef logic [CVMCU_INTR_ID_W-1:0]    cvmcu_intr_id_t;

endpackage

// File: rtl/cvmcu_intr_prio_enc.sv
// rtl/cvmcu_intr_prio_enc.sv - highest-index-wins priority encoder
module cvmcu_intr_prio_enc
  import cvmcu_intr_pkg::*;
#(
  parameter int NUM_IRQ = CVMCU_INTR_NUM_IRQ,
  parameter int ID_W    = CVMCU_INTR_ID_W
) (
  input  logic [NUM_IRQ-1:0] vec,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    valid = |vec;
    id    = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (vec[k]) id = ID_W'(k);
    end
  end

endmodule

// File: rtl/cvmcu_intr_ctrl.sv
// rtl/cvmcu_intr_ctrl.sv - edge-latched pending/mask interrupt source with ack retire
module cvmcu_intr_ctrl
  import cvmcu_intr_pkg::*;
#(
  parameter int NUM_IRQ = CVMCU_INTR_NUM_IRQ,
  parameter int ID_W    = CVMCU_INTR_ID_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] evt_i,
  input  logic [NUM_IRQ-1:0] sw_set_i,
  input  logic [NUM_IRQ-1:0] sw_clr_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] mask_wdata_i,
  input  logic               irq_ack_i,
  input  logic [ID_W-1:0]    irq_id_i,
  input  logic               lost_clr_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic               top_valid_o,
  output logic [ID_W-1:0]    top_id_o,
  output logic               ack_err_o,
  output logic [NUM_IRQ-1:0] lost_o
);

  logic [NUM_IRQ-1:0] evt_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] lost_q;
  logic               ack_err_q;

  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] ack_vec;
  logic [NUM_IRQ-1:0] legal_vec;
  logic [NUM_IRQ-1:0] lost_new;

  // Ids at or above NUM_IRQ decode to no line, so they can never be legal.
  always_comb begin
    ack_vec = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      ack_vec[k] = irq_ack_i && (irq_id_i == ID_W'(k));
    end
  end

  assign set_vec   = (evt_i & ~evt_q) | sw_set_i;
  assign legal_vec = ack_vec & pending_q & mask_q;
  assign lost_new  = set_vec & pending_q & ~legal_vec & ~sw_clr_i;

  always_ff @(posedge clk) begin
    evt_q <= evt_i;
    if (!reset_n) begin
      pending_q <= '0;
      mask_q    <= '0;
      lost_q    <= '0;
      ack_err_q <= 1'b0;
    end else begin
      // Clear beats set, set beats ack retire.
      pending_q <= ((pending_q & ~legal_vec) | set_vec) & ~sw_clr_i;
      if (mask_we_i) mask_q <= mask_wdata_i;
      lost_q    <= (lost_clr_i ? '0 : lost_q) | lost_new;
      ack_err_q <= irq_ack_i & ~(|legal_vec);
    end
  end

  assign irq_o     = pending_q & mask_q;
  assign pending_o = pending_q;
  assign mask_o    = mask_q;
  assign lost_o    = lost_q;
  assign ack_err_o = ack_err_q;

  cvmcu_intr_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .vec   (irq_o),
    .valid (top_valid_o),
    .id    (top_id_o)
  );

endmodule

// File: tb/tb_cvmcu_intr_ctrl.sv
// tb/tb_cvmcu_intr_ctrl.sv - scoreboard bench for cvmcu_intr_ctrl
module tb_cvmcu_intr_ctrl;
  import cvmcu_intr_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  cvmcu_intr_vec_t evt, sw_set, sw_clr, mask_wdata;
  logic            mask_we, irq_ack, lost_clr;
  cvmcu_intr_id_t  irq_id;
  cvmcu_intr_vec_t irq, pending, mask, lost;
  logic            top_valid, ack_err;
  cvmcu_intr_id_t  top_id;

  logic [15:0]     set16, mwd16;
  logic            mwe16, ack16;
  logic [4:0]      id16;
  logic [15:0]     irq16, pend16, mask16, lost16;
  logic            tv16, err16;
  logic [4:0]      tid16;

  always #5 clk = ~clk;

  cvmcu_intr_ctrl dut (
    .clk(clk), .reset_n(reset_n), .evt_i(evt), .sw_set_i(sw_set), .sw_clr_i(sw_clr),
    .mask_we_i(mask_we), .mask_wdata_i(mask_wdata), .irq_ack_i(irq_ack), .irq_id_i(irq_id),
    .lost_clr_i(lost_clr), .irq_o(irq), .pending_o(pending), .mask_o(mask),
    .top_valid_o(top_valid), .top_id_o(top_id), .ack_err_o(ack_err), .lost_o(lost)
  );

  cvmcu_intr_ctrl #(.NUM_IRQ(16), .ID_W(5)) dut16 (
    .clk(clk), .reset_n(reset_n), .evt_i(16'h0), .sw_set_i(set16), .sw_clr_i(16'h0),
    .mask_we_i(mwe16), .mask_wdata_i(mwd16), .irq_ack_i(ack16), .irq_id_i(id16),
    .lost_clr_i(1'b0), .irq_o(irq16), .pending_o(pend16), .mask_o(mask16),
    .top_valid_o(tv16), .top_id_o(tid16), .ack_err_o(err16), .lost_o(lost16)
  );

  typedef struct {
    string       name;
    logic [31:0] pend, msk, lst;
    logic        err, tv;
    logic [4:0]  tid;
    logic [15:0] p16;
    logic        e16;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  task automatic expect_s(input string nm, input logic [31:0] pend, input logic [31:0] msk,
                          input logic [31:0] lst, input logic err, input logic tv,
                          input logic [4:0] tid, input logic [15:0] p16, input logic e16);
    exp_t e;
    e.name = nm; e.pend = pend; e.msk = msk; e.lst = lst; e.err = err;
    e.tv = tv; e.tid = tid; e.p16 = p16; e.e16 = e16;
    q.push_back(e);
  endtask

  // Each expectation describes state right after the next rising edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        chk(e.name, "pending", pending, e.pend);
        chk(e.name, "mask", mask, e.msk);
        chk(e.name, "irq", irq, e.pend & e.msk);
        chk(e.name, "lost", lost, e.lst);
        chk(e.name, "ack_err", 32'(ack_err), 32'(e.err));
        chk(e.name, "top_valid", 32'(top_valid), 32'(e.tv));
        chk(e.name, "top_id", 32'(top_id), 32'(e.tid));
        chk(e.name, "pend16", 32'(pend16), 32'(e.p16));
        chk(e.name, "err16", 32'(err16), 32'(e.e16));
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    sw_set = '0; sw_clr = '0; mask_we = 1'b0; irq_ack = 1'b0; lost_clr = 1'b0;
    set16 = '0; mwe16 = 1'b0; ack16 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; evt = 32'h1; sw_set = '0; sw_clr = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; irq_id = '0; lost_clr = 1'b0;
    set16 = '0; mwd16 = '0; mwe16 = 1'b0; ack16 = 1'b0; id16 = '0;
    repeat (2) @(negedge clk);

    nxt(); expect_s("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); reset_n = 1'b1; expect_s("rel_held", 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); mask_we = 1; mask_wdata = 32'h8; expect_s("mask8", 0, 32'h8, 0, 0, 0, 0, 0, 0);
    nxt(); evt = 32'h9; expect_s("evt3", 32'h8, 32'h8, 0, 0, 1, 3, 0, 0);
    nxt(); mask_we = 1; mask_wdata = 32'hFFFF_FFFF; sw_set = 32'h0002_0000;
    expect_s("set17", 32'h0002_0008, 32'hFFFF_FFFF, 0, 0, 1, 17, 0, 0);
    nxt(); irq_ack = 1; irq_id = 17; set16 = 16'h4; mwe16 = 1; mwd16 = 16'hFFFF;
    expect_s("ack17", 32'h8, 32'hFFFF_FFFF, 0, 0, 1, 3, 16'h4, 0);
    nxt(); irq_ack = 1; irq_id = 3; expect_s("ack3", 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 16'h4, 0);
    nxt(); irq_ack = 1; irq_id = 5; expect_s("ack5_idle", 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 16'h4, 0);
    nxt(); ack16 = 1; id16 = 31; expect_s("ack31_n16", 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 16'h4, 1);
    nxt(); expect_s("err_clear", 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 16'h4, 0);
    nxt(); evt = 32'h89; expect_s("evt7", 32'h80, 32'hFFFF_FFFF, 0, 0, 1, 7, 16'h4, 0);
    nxt(); evt = 32'h09; expect_s("evt7_fall", 32'h80, 32'hFFFF_FFFF, 0, 0, 1, 7, 16'h4, 0);
    nxt(); evt = 32'h89; irq_ack = 1; irq_id = 7;
    expect_s("rise_ack7", 32'h80, 32'hFFFF_FFFF, 0, 0, 1, 7, 16'h4, 0);
    nxt(); evt = 32'h09; expect_s("fall2", 32'h80, 32'hFFFF_FFFF, 0, 0, 1, 7, 16'h4, 0);
    nxt(); evt = 32'h89; expect_s("lost7", 32'h80, 32'hFFFF_FFFF, 32'h80, 0, 1, 7, 16'h4, 0);
    nxt(); expect_s("lost_hold", 32'h80, 32'hFFFF_FFFF, 32'h80, 0, 1, 7, 16'h4, 0);
    nxt(); lost_clr = 1; expect_s("lost_clr", 32'h80, 32'hFFFF_FFFF, 0, 0, 1, 7, 16'h4, 0);
    nxt(); evt = 32'h09; expect_s("fall3", 32'h80, 32'hFFFF_FFFF, 0, 0, 1, 7, 16'h4, 0);
    nxt(); evt = 32'h89; lost_clr = 1;
    expect_s("lost_wins", 32'h80, 32'hFFFF_FFFF, 32'h80, 0, 1, 7, 16'h4, 0);
    nxt(); lost_clr = 1; sw_clr = 32'h80; expect_s("clr7", 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 16'h4, 0);
    nxt(); mask_we = 1; mask_wdata = 32'h0; sw_set = 32'h200;
    expect_s("set9_masked", 32'h200, 0, 0, 0, 0, 0, 16'h4, 0);
    nxt(); mask_we = 1; mask_wdata = 32'h200; expect_s("unmask9", 32'h200, 32'h200, 0, 0, 1, 9, 16'h4, 0);
    nxt(); sw_set = 32'h200; sw_clr = 32'h200; expect_s("set_clr9", 0, 32'h200, 0, 0, 0, 0, 16'h4, 0);
    nxt(); sw_set = 32'h10; expect_s("set4_masked", 32'h10, 32'h200, 0, 0, 0, 0, 16'h4, 0);
    nxt(); irq_ack = 1; irq_id = 4; expect_s("ack4_masked", 32'h10, 32'h200, 0, 1, 0, 0, 16'h4, 0);
    nxt(); mask_we = 1; mask_wdata = 32'hFFFF_FFFF; sw_set = 32'h1001;
    expect_s("pend_0_4_12", 32'h1011, 32'hFFFF_FFFF, 0, 0, 1, 12, 16'h4, 0);
    nxt(); reset_n = 1'b0; irq_ack = 1; irq_id = 12; sw_set = 32'h2;
    expect_s("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); reset_n = 1'b1; expect_s("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); expect_s("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d required=0 entries left", q.size());
    end
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cvmcu_intr_ctrl.md
Name: cvmcu_intr_ctrl

Overview:
- Interrupt-source end of the CV-MCU core interrupt interface; drives the level `irq` lines that the core-side monitor and checker observe.
- Edge-detects peripheral events and latches them as pending, with software set/clear.
- Gates pending lines with a mask and retires each line on the core's ack/id handshake.
- Sits between peripheral event sources and the core.

Parameters:
- NUM_IRQ, 32, number of interrupt lines (1..32).
- ID_W, 5, width of the interrupt id; must satisfy 2**ID_W >= NUM_IRQ.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- evt_i  in  NUM_IRQ  peripheral event levels; rising edge = event.
- sw_set_i  in  NUM_IRQ  per-line software set strobe, 1-cycle.
- sw_clr_i  in  NUM_IRQ  per-line software clear strobe, 1-cycle.
- mask_we_i  in  1  mask write enable.
- mask_wdata_i  in  NUM_IRQ  new mask value (1 = enabled).
- irq_ack_i  in  1  core acknowledge, 1-cycle pulse.
- irq_id_i  in  ID_W  id being acknowledged; valid with irq_ack_i.
- lost_clr_i  in  1  clears all lost_o bits.
- irq_o  out  NUM_IRQ  interrupt lines to core.
- pending_o  out  NUM_IRQ  pending register.
- mask_o  out  NUM_IRQ  mask register.
- top_valid_o  out  1  at least one line has irq_o = 1.
- top_id_o  out  ID_W  highest-index line with irq_o = 1; 0 when none.
- ack_err_o  out  1  1-cycle pulse flagging an illegal ack.
- lost_o  out  NUM_IRQ  sticky: event arrived while the line was already pending.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - pending, mask, lost and ack_err all go to 0.
  - evt_q loads evt_i, so lines already high at reset release do not generate events.
  - All outputs read 0 after the edge.
- Edge detect: rise = evt_i & ~evt_q; evt_q <= evt_i every cycle.
- Per-line pending next state, in priority order:
  1. sw_clr_i[k] → 0.
  2. rise[k] | sw_set_i[k] → 1.
  3. Legal ack of k → 0.
  4. Otherwise hold.
- Set and ack on the same line in the same cycle: line stays pending, lost not set.
- Lost: lost[k] <= 1 when (rise[k] | sw_set_i[k]) & pending[k] & ~legal_ack_k & ~sw_clr_i[k].
- lost_clr_i clears all lost bits; a same-cycle new lost event wins (bit stays 1).
- irq_o = pending_q & mask_q, combinational from registers, no input-to-output combinational path.
  - Latency: evt_i rises in cycle N → pending_o and irq_o high in N+1.
- Mask: mask_we_i loads mask_wdata_i at the edge.
  - Masked lines still latch pending and report lost.
  - Unmasking a pending line raises irq_o the next cycle.
- Ack handshake:
  - Legal only when irq_ack_i = 1, irq_id_i < NUM_IRQ, pending[id] = 1 and mask[id] = 1.
  - Legal ack clears pending[id] at the edge; irq_o[id] drops the cycle after the ack.
  - Illegal ack: no state change; ack_err_o = 1 for exactly the following cycle.
  - ack_err_o is registered and self-clears.
  - The core must not issue back-to-back acks on the same id; a second ack is illegal and flagged.
- Priority: top_id_o/top_valid_o are combinational from irq_o; highest index wins.
- Reset mid-operation: pending, mask and lost are cleared regardless of in-flight ack or set strobes at that edge.

Decomposition:
- Package cvmcu_intr_pkg:
  - CVMCU_INTR_NUM_IRQ = 32, CVMCU_INTR_ID_W = 5.
  - typedef cvmcu_intr_vec_t (logic [NUM_IRQ-1:0]).
  - typedef cvmcu_intr_id_t (logic [ID_W-1:0]).
- Sub-module cvmcu_intr_prio_enc (parameterised NUM_IRQ/ID_W): vector in → valid + highest set index out.

Test Plan:
- Reset release with evt_i = 32'h0000_0001 held high → pending_o = 0, irq_o = 0; then 0→1 on evt_i[3] with mask = 32'h8 → irq_o = 32'h8 one cycle later, top_id_o = 3.
- Lines 3 and 17 pending, mask = all-ones, ack id 17 → irq_o[17] drops next cycle, top_id_o = 3; ack id 3 → irq_o = 0, top_valid_o = 0.
- Ack id 5 while pending[5] = 0, then ack id 31 with NUM_IRQ = 16 → ack_err_o pulses 1 cycle each; pending_o unchanged.
- evt_i[7] rise coincident with legal ack of 7 → pending_o[7] stays 1, lost_o[7] = 0; second rise while pending → lost_o[7] = 1 until lost_clr_i.
- mask = 0, sw_set_i[9] → pending_o[9] = 1, irq_o = 0; mask_we_i with 32'h200 → irq_o[9] = 1 next cycle; sw_set_i[9] and sw_clr_i[9] together → pending_o[9] = 0.
- reset_n low for one cycle during an ack with lines 0, 4 and 12 pending → all outputs 0 the cycle after; no ack_err_o pulse.
